act_unit: RTL

//  Activation stage directly downstream of the aggregator (agg) in the NNA datapath.
//  - Accepts signed aggregated sums; applies ReLU, right-shift requantisation and unsigned saturation.
//  - Optionally applies 1x2 max-pooling.
//  - Buffers results in a small FIFO and presents them to the writeback stage over a valid/ready handshake.

---
 rtl/nna_pkg.sv | 10 +
 rtl/act_fifo.sv | 41 ++++
 rtl/act_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/nna_pkg.sv
// nna_pkg: shared FIFO entry layout, pool FSM states and saturation constant for the NNA activation stage
package nna_pkg;
  localparam int OUT_WIDTH = 8;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;
  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } entry_t;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/act_fifo.sv
// act_fifo: synchronous FIFO; an entry written into an empty FIFO surfaces one cycle later (no bypass)
module act_fifo #(
  parameter int width = 9,
  parameter int depth = 4,
  localparam int aw = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic [aw:0]      count,
  output logic             full,
  output logic             empty,
  output logic             hidden
);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wptr, rptr;
  logic push_d;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      push_d <= 1'b0;
    end else begin
      wptr   <= push ? wptr + 1'b1 : wptr;
      rptr   <= pop ? rptr + 1'b1 : rptr;
      count  <= count + (aw+1)'(push) - (aw+1)'(pop);
      push_d <= push;
    end
  end
  assign dout   = mem[rptr];
  assign empty  = count == '0;
  assign full   = count == (aw+1)'(depth);
  // the only entry was written on the last edge: keep it off the output for one cycle
  assign hidden = push_d & (count == (aw+1)'(1));
endmodule

// File: rtl/act_unit.sv
// act_unit: ReLU + shift requantisation + saturation, optional 1x2 max-pool, FIFO-buffered valid/ready output
module act_unit
  import nna_pkg::*;
#(
  parameter int agg_width   = 12,
  parameter int shift_width = 4,
  parameter int fifo_depth  = 4,
  localparam int out_width  = OUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [agg_width-1:0]   in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   pool_en,
  input  logic [shift_width-1:0] shift_amt,
  output logic                   out_valid,
  output logic [out_width-1:0]   out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   sat_seen
);
  localparam int cw = $clog2(fifo_depth) + 1;
  logic [agg_width-1:0] relu, shifted;
  logic [out_width-1:0] act_val, s1_data, hold;
  logic clip, in_fire, s1_valid, s1_last, push, pop, hold_ld, full, empty, hidden;
  logic [cw-1:0] count;
  entry_t push_data, head;
  state_t state, state_nx;
  assign in_fire = in_valid & in_ready;
  assign relu    = in_data[agg_width-1] ? '0 : in_data;
  assign shifted = relu >> shift_amt;
  assign clip    = shifted > agg_width'(OUT_MAX);
  assign act_val = clip ? OUT_MAX : shifted[out_width-1:0];
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      sat_seen <= 1'b0;
      hold     <= '0;
      state    <= ST_IDLE;
    end else begin
      s1_valid <= in_fire;
      s1_data  <= in_fire ? act_val : s1_data;
      s1_last  <= in_fire ? in_last : s1_last;
      sat_seen <= sat_seen | (in_fire & clip);
      hold     <= hold_ld ? s1_data : hold;
      state    <= state_nx;
    end
  end
  // pool_en only matters when a value arrives in IDLE, so pairs are never split by a mode change
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    hold_ld   = 1'b0;
    push_data = '{last: s1_last, data: s1_data};
    if (s1_valid) begin
      if (state == ST_HOLD) begin
        push      = 1'b1;
        push_data = '{last: s1_last, data: hold > s1_data ? hold : s1_data};
        state_nx  = ST_IDLE;
      end else if (pool_en && !s1_last) begin
        hold_ld  = 1'b1;
        state_nx = ST_HOLD;
      end else begin
        push = 1'b1;
      end
    end
  end
  act_fifo #(.width($bits(entry_t)), .depth(fifo_depth)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .dout   (head),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .hidden (hidden)
  );
  // reserving a slot for the value in s1 means a push never lands on a full FIFO
  assign in_ready  = rst & ~full & ((count + cw'(s1_valid)) < cw'(fifo_depth));
  assign out_valid = ~empty & ~hidden;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
endmodule
